// File: rtl/reg_ctrl_pkg.sv
// Shared command codes, FSM state encoding and helpers
// for the byte-stream register-file controller.
package reg_ctrl_pkg;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DLO,
    WR_DHI,
    WR_EXEC,
    RD_ADDR,
    RD_EXEC,
    RD_WAIT,
    TX_LO,
    TX_HI
  } state_e;

  function automatic logic addr_ok(
    input logic [7:0]  b,
    input int unsigned aw
  );
    return (b >> aw) == 8'd0;
  endfunction

endpackage

// File: rtl/reg_file_ctrl_if.sv
// Signal bundle between the command controller
// and its host byte link / register file.
interface reg_file_ctrl_if #(
  parameter int ADDR_W = 4
) ();

  logic [7:0]        RX_P_DATA;
  logic              RX_D_VLD;
  logic              WrEn;
  logic              RdEn;
  logic [ADDR_W-1:0] Address;
  logic [15:0]       WrData;
  logic [15:0]       RdData;
  logic [7:0]        TX_P_DATA;
  logic              TX_D_VLD;
  logic              TX_RDY;
  logic              CMD_ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, TX_RDY,
    output WrEn, RdEn, Address, WrData,
    output TX_P_DATA, TX_D_VLD, CMD_ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, TX_RDY,
    input  WrEn, RdEn, Address, WrData,
    input  TX_P_DATA, TX_D_VLD, CMD_ERR
  );

endinterface

// File: rtl/frame_timer.sv
// Inter-byte timeout: counts enabled idle cycles,
// flags the TMO_CYC-th one; a clear in that cycle wins.
module frame_timer #(
  parameter int TMO_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TMO_CYC + 1);
  localparam logic [CW:0] LIMIT = (CW + 1)'(TMO_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   nxt;

  always_comb begin
    nxt     = {1'b0, cnt_q} + 1'b1;
    expired = enable && !clear && (nxt == LIMIT);
    cnt_d   = nxt[CW-1:0];
    if (clear || !enable || expired) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_file_ctrl.sv
// Byte-command front end for a register file: parses
// write/read frames and streams read data back.
module reg_file_ctrl
  import reg_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int TMO_CYC = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        RX_P_DATA,
  input  logic              RX_D_VLD,
  output logic              WrEn,
  output logic              RdEn,
  output logic [ADDR_W-1:0] Address,
  output logic [15:0]       WrData,
  input  logic [15:0]       RdData,
  output logic [7:0]        TX_P_DATA,
  output logic              TX_D_VLD,
  input  logic              TX_RDY,
  output logic              CMD_ERR
);

  state_e            state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       hold_q, hold_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_vld_q, tx_vld_d;
  logic              err_q, err_d;

  logic vld;
  logic a_ok;
  logic is_cmd;
  logic tmr_en;
  logic tmo;

  assign vld    = RX_D_VLD;
  assign a_ok   = addr_ok(RX_P_DATA, ADDR_W);
  assign is_cmd = (RX_P_DATA == CMD_WR) ||
                  (RX_P_DATA == CMD_RD);
  assign tmr_en = (state_q == WR_ADDR) ||
                  (state_q == WR_DLO)  ||
                  (state_q == WR_DHI)  ||
                  (state_q == RD_ADDR);

  frame_timer #(
    .TMO_CYC (TMO_CYC)
  ) u_timer (
    .clk     (CLK),
    .rst     (RST),
    .clear   (vld),
    .enable  (tmr_en),
    .expired (tmo)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      hold_q    <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      hold_q    <= hold_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (vld && RX_P_DATA == CMD_WR) state_d = WR_ADDR;
        else if (vld && RX_P_DATA == CMD_RD) state_d = RD_ADDR;
      end
      WR_ADDR: begin
        if (vld) state_d = a_ok ? WR_DLO : IDLE;
        else if (tmo) state_d = IDLE;
      end
      WR_DLO: begin
        if (vld) state_d = WR_DHI;
        else if (tmo) state_d = IDLE;
      end
      WR_DHI: begin
        if (vld) state_d = WR_EXEC;
        else if (tmo) state_d = IDLE;
      end
      WR_EXEC: state_d = IDLE;
      RD_ADDR: begin
        if (vld) state_d = a_ok ? RD_EXEC : IDLE;
        else if (tmo) state_d = IDLE;
      end
      RD_EXEC: state_d = RD_WAIT;
      RD_WAIT: state_d = TX_LO;
      TX_LO:   if (TX_RDY) state_d = TX_HI;
      TX_HI:   if (TX_RDY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    err_d     = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hold_d    = hold_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = tx_vld_q;
    unique case (state_q)
      IDLE: err_d = vld && !is_cmd;
      WR_ADDR, RD_ADDR: begin
        if (vld && a_ok) begin
          addr_d  = RX_P_DATA[ADDR_W-1:0];
          rd_en_d = (state_q == RD_ADDR);
        end
        err_d = vld ? !a_ok : tmo;
      end
      WR_DLO: begin
        if (vld) wdata_d[7:0] = RX_P_DATA;
        err_d = !vld && tmo;
      end
      WR_DHI: begin
        if (vld) wdata_d[15:8] = RX_P_DATA;
        wr_en_d = vld;
        err_d   = !vld && tmo;
      end
      RD_WAIT: begin
        // Low byte goes straight out; hold keeps the high byte.
        hold_d    = RdData;
        tx_data_d = RdData[7:0];
        tx_vld_d  = 1'b1;
        err_d     = vld;
      end
      TX_LO: begin
        if (TX_RDY) tx_data_d = hold_q[15:8];
        err_d = vld;
      end
      TX_HI: begin
        if (TX_RDY) tx_vld_d = 1'b0;
        err_d = vld;
      end
      WR_EXEC, RD_EXEC: err_d = vld;
      default: err_d = 1'b0;
    endcase
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = addr_q;
  assign WrData    = wdata_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign CMD_ERR   = err_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Scoreboard bench: a frame-level model predicts events,
// a negedge monitor matches DUT events in order and cycle.
module tb_reg_file_ctrl;

  localparam int AW  = 4;
  localparam int TMO = 40;

  localparam int K_ERR = 0;
  localparam int K_WR  = 1;
  localparam int K_RD  = 2;
  localparam int K_TX  = 3;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  reg_file_ctrl_if #(.ADDR_W(AW)) bus ();

  reg_file_ctrl #(
    .ADDR_W  (AW),
    .TMO_CYC (TMO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_P_DATA (bus.RX_P_DATA),
    .RX_D_VLD  (bus.RX_D_VLD),
    .WrEn      (bus.WrEn),
    .RdEn      (bus.RdEn),
    .Address   (bus.Address),
    .WrData    (bus.WrData),
    .RdData    (bus.RdData),
    .TX_P_DATA (bus.TX_P_DATA),
    .TX_D_VLD  (bus.TX_D_VLD),
    .TX_RDY    (bus.TX_RDY),
    .CMD_ERR   (bus.CMD_ERR)
  );

  always #5 CLK = ~CLK;

  // register-file stub driven by the DUT's controls
  logic [15:0] rf [16] = '{default: 16'h0};
  always @(posedge CLK) begin
    if (bus.WrEn === 1'b1) rf[bus.Address] <= bus.WrData;
    if (bus.RdEn === 1'b1) bus.RdData <= rf[bus.Address];
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  ev_t exp_q[$];

  // reference model state: frame bytes so far, idle gap,
  // drop window length, bytes still to transmit
  logic [7:0]  frame[$];
  logic [7:0]  txq[$];
  logic [15:0] mem [16] = '{default: 16'h0};
  int gap  = 0;
  int busy = 0;

  task automatic push(input int k, input int c, input int v);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic model_step(input bit rst, input bit vld,
                            input logic [7:0] b, input bit rdy);
    bit sent;
    int a;
    logic [15:0] d;
    sent = 1'b0;
    if (busy == 0 && txq.size() > 0 && rdy) begin
      push(K_TX, cyc, int'(txq[0]));
      sent = 1'b1;
    end
    if (rst) begin
      frame.delete();
      txq.delete();
      gap  = 0;
      busy = 0;
      return;
    end
    if (busy > 0 || txq.size() > 0) begin
      if (vld) push(K_ERR, cyc + 1, 0);
      if (busy > 0) busy--;
      if (sent) void'(txq.pop_front());
    end else if (frame.size() == 0) begin
      if (vld) begin
        if (b == 8'hAA || b == 8'hBB) begin
          frame.push_back(b);
          gap = 0;
        end else begin
          push(K_ERR, cyc + 1, 0);
        end
      end
    end else if (vld) begin
      gap = 0;
      if (frame.size() == 1 && int'(b) >= (1 << AW)) begin
        push(K_ERR, cyc + 1, 0);
        frame.delete();
      end else begin
        frame.push_back(b);
        a = int'(frame[1]);
        if (frame[0] == 8'hBB) begin
          push(K_RD, cyc + 1, a);
          busy = 2;
          d = mem[a[3:0]];
          txq.push_back(d[7:0]);
          txq.push_back(d[15:8]);
          frame.delete();
        end else if (frame.size() == 4) begin
          d = {frame[3], frame[2]};
          push(K_WR, cyc + 1, (a << 16) | int'(d));
          mem[a[3:0]] = d;
          busy = 1;
          frame.delete();
        end
      end
    end else begin
      gap++;
      if (gap == TMO) begin
        push(K_ERR, cyc + 1, 0);
        frame.delete();
      end
    end
  endtask

  task automatic step(input bit rst, input bit vld,
                      input logic [7:0] b, input bit rdy);
    @(posedge CLK);
    #1;
    cyc++;
    RST           = rst;
    bus.RX_D_VLD  = vld;
    bus.RX_P_DATA = vld ? b : 8'($urandom);
    bus.TX_RDY    = rdy;
    model_step(rst, vld, b, rdy);
  endtask

  task automatic send(input logic [7:0] b, input bit rdy = 1'b1);
    step(1'b0, 1'b1, b, rdy);
  endtask

  task automatic idle(input int n, input bit rdy = 1'b1);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, rdy);
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if (bus.WrEn !== 1'b0 || bus.RdEn !== 1'b0 ||
        bus.TX_D_VLD !== 1'b0 || bus.CMD_ERR !== 1'b0 ||
        bus.Address !== '0 || bus.WrData !== '0 ||
        bus.TX_P_DATA !== '0) begin
      errors++;
      $display("FAIL %s: wr=%b rd=%b txv=%b err=%b a=%h wd=%h txd=%h, required all 0",
               nm, bus.WrEn, bus.RdEn, bus.TX_D_VLD, bus.CMD_ERR,
               bus.Address, bus.WrData, bus.TX_P_DATA);
    end
  endtask

  // monitor
  task automatic expect_ev(input int k, input int v, input string nm);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected at cyc=%0d val=%h, required no event",
               nm, cyc, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.val != v) begin
        errors++;
        $display("FAIL %s: got kind=%0d cyc=%0d val=%h, required kind=%0d cyc=%0d val=%h",
                 nm, k, cyc, v, e.kind, e.cyc, e.val);
      end
    end
  endtask

  bit         p_vld = 1'b0;
  bit         p_rdy = 1'b0;
  bit         p_rst = 1'b1;
  logic [7:0] p_dat = '0;

  always @(negedge CLK) begin
    if (cyc > 0) begin
      checks++;
      if (bus.WrEn === 1'b1 && bus.RdEn === 1'b1) begin
        errors++;
        $display("FAIL wr_rd_overlap: WrEn=1 RdEn=1 at cyc=%0d, required not both", cyc);
      end
      if (bus.CMD_ERR === 1'b1) expect_ev(K_ERR, 0, "cmd_err");
      if (bus.WrEn === 1'b1)
        expect_ev(K_WR, int'({bus.Address, bus.WrData}), "write");
      if (bus.RdEn === 1'b1) expect_ev(K_RD, int'(bus.Address), "read");
      if (bus.TX_D_VLD === 1'b1 && bus.TX_RDY === 1'b1)
        expect_ev(K_TX, int'(bus.TX_P_DATA), "tx_byte");
      if (p_vld && !p_rdy && !p_rst) begin
        checks++;
        if (bus.TX_D_VLD !== 1'b1 || bus.TX_P_DATA !== p_dat) begin
          errors++;
          $display("FAIL tx_hold: vld=%b data=%h, required vld=1 data=%h",
                   bus.TX_D_VLD, bus.TX_P_DATA, p_dat);
        end
      end
      p_vld = (bus.TX_D_VLD === 1'b1);
      p_rdy = (bus.TX_RDY === 1'b1);
      p_rst = RST;
      p_dat = bus.TX_P_DATA;
    end
  end

  // random frame source
  logic [7:0] sq[$];

  task automatic gen_frame();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 3 || r == 9) begin
      sq.push_back(8'hAA);
      if ($urandom_range(0, 7) == 0) sq.push_back(8'($urandom_range(16, 255)));
      else sq.push_back(8'($urandom_range(0, 15)));
      if (r != 9) begin
        sq.push_back(8'($urandom));
        sq.push_back(8'($urandom));
      end
    end else if (r <= 7) begin
      sq.push_back(8'hBB);
      if ($urandom_range(0, 7) == 0) sq.push_back(8'($urandom_range(16, 255)));
      else sq.push_back(8'($urandom_range(0, 15)));
    end else begin
      sq.push_back(8'($urandom));
    end
  endtask

  function automatic int pick_gap();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 85) return int'($urandom_range(0, 2));
    if (r < 95) return int'($urandom_range(5, 12));
    return int'($urandom_range(TMO - 2, TMO + 3));
  endfunction

  initial begin
    int held;
    int gap_left;
    logic [7:0] b;
    bus.RX_D_VLD  = 1'b0;
    bus.RX_P_DATA = 8'h00;
    bus.TX_RDY    = 1'b1;

    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check_zero("reset_state");

    // write AA,03,34,12
    send(8'hAA); send(8'h03); send(8'h34); send(8'h12);
    idle(3);

    // read BB,03 with ready
    send(8'hBB); send(8'h03);
    idle(8);

    // read with back-pressure
    send(8'hBB); send(8'h03, 1'b0);
    idle(3, 1'b0);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      if (bus.TX_D_VLD === 1'b1 && bus.TX_P_DATA === 8'h34) held++;
    end
    checks++;
    if (held != 10) begin
      errors++;
      $display("FAIL backpressure_hold: held=%0d, required 10", held);
    end
    idle(6);

    // errors: bad command, out-of-range address
    send(8'h55); idle(2);
    send(8'hBB); send(8'h13); idle(3);

    // timeout then normal read
    send(8'hAA); send(8'h05);
    idle(TMO + 2);
    send(8'hBB); send(8'h05);
    idle(8);

    // reset mid-frame
    send(8'hAA); send(8'h02); send(8'hFF);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check_zero("reset_midframe");
    idle(4);

    // randomized traffic
    gap_left = 0;
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      bit rdy;
      if (sq.size() == 0) gen_frame();
      rst = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      if (gap_left > 0) begin
        gap_left--;
        step(rst, 1'b0, 8'h00, rdy);
      end else begin
        b = sq.pop_front();
        step(rst, 1'b1, b, rdy);
        gap_left = pick_gap();
      end
    end

    idle(TMO + 20);
    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d events outstanding, first kind=%0d cyc=%0d, required 0",
               exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_ctrl.md
REG_FILE_CTRL -- requirements
Module: reg_file_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter ADDR_W SHALL default to 4 and set the register-file address width.
REQ-003 Parameter TMO_CYC SHALL default to 1000 and set the inter-byte frame timeout in cycles.
REQ-004 CLK  in  1  system clock.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 RX_P_DATA  in  8  received command byte; RX_D_VLD  in  1  one-cycle byte strobe.
REQ-007 WrEn  out  1; RdEn  out  1; Address  out  ADDR_W; WrData  out  16; these are the register-file controls.
REQ-008 RdData  in  16  register-file read data, valid the cycle after RdEn.
REQ-009 TX_P_DATA  out  8; TX_D_VLD  out  1; TX_RDY  in  1; a byte transfers when TX_D_VLD and TX_RDY are both high.
REQ-010 CMD_ERR  out  1  one-cycle error pulse.

Function
REQ-011 Write frame SHALL be 0xAA, address byte, data low byte, data high byte; read frame SHALL be 0xBB, address byte.
REQ-012 States SHALL be IDLE, WR_ADDR, WR_DLO, WR_DHI, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_LO, TX_HI.
REQ-013 In IDLE: 0xAA goes to WR_ADDR; 0xBB goes to RD_ADDR; any other byte stays in IDLE and pulses CMD_ERR.
REQ-014 An address byte with nonzero bits [7:ADDR_W] SHALL abort the frame to IDLE and pulse CMD_ERR.
REQ-015 WrEn SHALL be high for exactly one cycle, the cycle after the data high byte is accepted; Address and WrData SHALL be stable during it.
REQ-016 RdEn SHALL be high for exactly one cycle, the cycle after the address byte is accepted (RD_EXEC).
REQ-017 RdData SHALL be captured in RD_WAIT into an internal 16-bit holding register.
REQ-018 TX_LO SHALL send holding[7:0], then TX_HI SHALL send holding[15:8].
REQ-019 TX_D_VLD SHALL stay high with stable TX_P_DATA until TX_RDY is seen; the controller returns to IDLE after the high byte transfers.
REQ-020 Minimum latency from read address strobe to first TX_D_VLD SHALL be 3 cycles.
REQ-021 RX_D_VLD in WR_EXEC, RD_EXEC, RD_WAIT, TX_LO or TX_HI SHALL be dropped and SHALL pulse CMD_ERR.
REQ-022 The timeout counter SHALL clear on each accepted byte and count in WR_ADDR, WR_DLO, WR_DHI and RD_ADDR only.
REQ-023 When the counter reaches TMO_CYC, the block SHALL go to IDLE and pulse CMD_ERR.
REQ-024 A byte arriving in the same cycle as timeout expiry SHALL win; no timeout occurs in that cycle.
REQ-025 There SHALL be no timeout in TX states; the controller waits on TX_RDY indefinitely.
REQ-026 WrEn and RdEn SHALL never be high in the same cycle.

Reset
REQ-027 On RST, state SHALL go to IDLE; WrEn, RdEn, TX_D_VLD and CMD_ERR SHALL be 0; Address, WrData, TX_P_DATA, the holding register and the counter SHALL be 0.
REQ-028 Reset mid-frame or mid-transmit SHALL discard the partial frame; no pending WrEn or RdEn shall issue after reset.

Structure
REQ-029 Command codes (0xAA, 0xBB) and the state encoding SHALL reside in shared package reg_ctrl_pkg.
REQ-030 The timeout counter SHALL be sub-module frame_timer (inputs clear, enable; output expired).
REQ-031 The FSM, the holding register and the output registers SHALL live in reg_file_ctrl; all outputs SHALL be registered.

Verification
REQ-032 Write test: send AA,03,34,12 -> one-cycle WrEn with Address=3 and WrData=0x1234; CMD_ERR stays 0.
REQ-033 Read test: send BB,03 with RdData=0x1234 and TX_RDY=1 -> RdEn pulse, then TX bytes 0x34 then 0x12, then IDLE.
REQ-034 Back-pressure test: hold TX_RDY=0 for 10 cycles during a read -> TX_D_VLD and TX_P_DATA=0x34 stay stable, no extra bytes.
REQ-035 Error test: send 0x55 in IDLE -> CMD_ERR pulse; send BB,0x13 -> CMD_ERR, no RdEn.
REQ-036 Timeout test: send AA,05, then idle TMO_CYC cycles -> CMD_ERR, IDLE, no WrEn; a following BB,05 is served normally.
REQ-037 Reset test: assert RST after AA,02,FF -> no WrEn; all outputs 0 the next cycle.
